// File: rtl/piece_sequencer.sv
// Piece lifecycle sequencer: spawn, gravity, key auto-repeat, lock delay and game-over.
// Outputs registered one frame after sampled inputs; blocked or out-arbitrated key pulses drop, a late gravity tick waits.
module piece_sequencer #(
    parameter int GRAVITY_FRAMES = 30,
    parameter int LOCK_DELAY     = 15,
    parameter int KEY_REPEAT     = 8
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic key_left,
    input  logic key_right,
    input  logic key_down,
    input  logic key_rotate,
    input  logic leftEdge,
    input  logic rightEdge,
    input  logic bottomEdge,
    input  logic spawn_blocked,
    input  logic lock_done,
    output logic a_enable,
    output logic d_enable,
    output logic s_enable,
    output logic r_enable,
    output logic newShape,
    output logic lock_req,
    output logic game_over
);
    typedef enum logic [2:0] {SPAWN, FALL, LOCK_WAIT, LOCK, OVER} state_t;

    localparam logic [7:0] GRAV_LAST = 8'(GRAVITY_FRAMES - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_DELAY - 1);
    localparam logic [7:0] REP_LAST  = 8'(KEY_REPEAT - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_grav_cnt, w_grav_nxt;
    logic [7:0] r_lock_cnt, w_lock_nxt;
    logic [7:0] r_rep_cnt [3];
    logic [7:0] w_rep_nxt [3];
    logic [3:0] r_key_prev;
    logic [3:0] w_keys;
    logic [3:0] w_rise;
    logic [2:0] w_fire;
    logic       w_lr_both, w_left_ok, w_right_ok, w_rot_ok, w_side_busy;
    logic       w_down_ok, w_grav_due, w_side_en;
    logic       r_a_en, r_d_en, r_s_en, r_r_en, r_new_shape, r_lock_req, r_game_over;
    logic       w_a_nxt, w_d_nxt, w_s_nxt, w_r_nxt, w_ns_nxt, w_lock_req_nxt, w_go_nxt;

    // Index 0..2 = left, right, down (repeating); index 3 = rotate (edge only).
    always_comb begin
        w_keys = {key_rotate, key_down, key_right, key_left};
        w_rise = w_keys & ~r_key_prev;
        for (int i = 0; i < 3; i++) begin
            w_fire[i]    = w_rise[i];
            w_rep_nxt[i] = '0;
            if (r_state != SPAWN && w_keys[i] && r_key_prev[i]) begin
                if (r_rep_cnt[i] == REP_LAST)
                    w_fire[i] = 1'b1;
                else
                    w_rep_nxt[i] = r_rep_cnt[i] + 8'd1;
            end
        end
    end

    assign w_lr_both   = key_left & key_right;
    assign w_left_ok   = w_fire[0] & ~leftEdge & ~w_lr_both;
    assign w_right_ok  = w_fire[1] & ~rightEdge & ~w_lr_both;
    assign w_rot_ok    = w_rise[3];
    assign w_side_busy = w_left_ok | w_right_ok | w_rot_ok;
    assign w_down_ok   = w_fire[2] & ~bottomEdge;
    assign w_grav_due  = (r_grav_cnt == GRAV_LAST) & ~bottomEdge;

    always_comb begin
        w_state_nxt    = r_state;
        w_grav_nxt     = r_grav_cnt;
        w_lock_nxt     = r_lock_cnt;
        w_side_en      = 1'b0;
        w_s_nxt        = 1'b0;
        w_ns_nxt       = 1'b0;
        w_lock_req_nxt = 1'b0;
        w_go_nxt       = 1'b0;
        case (r_state)
            SPAWN: begin
                w_grav_nxt = '0;
                w_lock_nxt = '0;
                if (spawn_blocked) begin
                    w_state_nxt = OVER;
                    w_go_nxt    = 1'b1;
                end else begin
                    w_state_nxt = FALL;
                    w_ns_nxt    = 1'b1;
                end
            end
            FALL: begin
                w_side_en = 1'b1;
                if (bottomEdge) begin
                    w_state_nxt = LOCK_WAIT;
                    w_lock_nxt  = '0;
                    w_grav_nxt  = '0;
                end else if (!w_side_busy && (w_down_ok || w_grav_due)) begin
                    w_s_nxt    = 1'b1;
                    w_grav_nxt = '0;
                end else if (r_grav_cnt != GRAV_LAST) begin
                    // A due tick that lost arbitration stays parked at the last count.
                    w_grav_nxt = r_grav_cnt + 8'd1;
                end
            end
            LOCK_WAIT: begin
                if (!bottomEdge) begin
                    w_side_en   = 1'b1;
                    w_state_nxt = FALL;
                    w_grav_nxt  = '0;
                end else if (r_lock_cnt == LOCK_LAST || w_rise[2]) begin
                    w_state_nxt    = LOCK;
                    w_lock_req_nxt = 1'b1;
                end else begin
                    w_side_en  = 1'b1;
                    w_lock_nxt = r_lock_cnt + 8'd1;
                end
            end
            LOCK: begin
                if (lock_done)
                    w_state_nxt = SPAWN;
                else
                    w_lock_req_nxt = 1'b1;
            end
            OVER:    w_go_nxt = 1'b1;
            default: w_state_nxt = SPAWN;
        endcase
        w_a_nxt = w_side_en & w_left_ok;
        w_d_nxt = w_side_en & w_right_ok & ~w_left_ok;
        w_r_nxt = w_side_en & w_rot_ok & ~w_left_ok & ~w_right_ok;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= SPAWN;
            r_grav_cnt  <= '0;
            r_lock_cnt  <= '0;
            r_key_prev  <= '0;
            for (int i = 0; i < 3; i++) r_rep_cnt[i] <= '0;
            r_a_en      <= 1'b0;
            r_d_en      <= 1'b0;
            r_s_en      <= 1'b0;
            r_r_en      <= 1'b0;
            r_new_shape <= 1'b0;
            r_lock_req  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grav_cnt  <= w_grav_nxt;
            r_lock_cnt  <= w_lock_nxt;
            r_key_prev  <= w_keys;
            for (int i = 0; i < 3; i++) r_rep_cnt[i] <= w_rep_nxt[i];
            r_a_en      <= w_a_nxt;
            r_d_en      <= w_d_nxt;
            r_s_en      <= w_s_nxt;
            r_r_en      <= w_r_nxt;
            r_new_shape <= w_ns_nxt;
            r_lock_req  <= w_lock_req_nxt;
            r_game_over <= w_go_nxt;
        end
    end

    assign a_enable  = r_a_en;
    assign d_enable  = r_d_en;
    assign s_enable  = r_s_en;
    assign r_enable  = r_r_en;
    assign newShape  = r_new_shape;
    assign lock_req  = r_lock_req;
    assign game_over = r_game_over;
endmodule

// File: tb/tb_piece_sequencer.sv
// Directed scenarios then randomized frames, every frame compared against a time-stamp based reference model.
module tb_piece_sequencer;
    localparam int G  = 4;
    localparam int LD = 3;
    localparam int R  = 2;

    logic frame_clk = 1'b0;
    logic Reset = 1'b1;
    logic key_left = 1'b0, key_right = 1'b0, key_down = 1'b0, key_rotate = 1'b0;
    logic leftEdge = 1'b0, rightEdge = 1'b0, bottomEdge = 1'b0;
    logic spawn_blocked = 1'b0, lock_done = 1'b0;
    logic a_enable, d_enable, s_enable, r_enable, newShape, lock_req, game_over;

    piece_sequencer #(.GRAVITY_FRAMES(G), .LOCK_DELAY(LD), .KEY_REPEAT(R)) dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .key_left(key_left), .key_right(key_right), .key_down(key_down), .key_rotate(key_rotate),
        .leftEdge(leftEdge), .rightEdge(rightEdge), .bottomEdge(bottomEdge),
        .spawn_blocked(spawn_blocked), .lock_done(lock_done),
        .a_enable(a_enable), .d_enable(d_enable), .s_enable(s_enable), .r_enable(r_enable),
        .newShape(newShape), .lock_req(lock_req), .game_over(game_over)
    );

    always #5 frame_clk = ~frame_clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: frame numbers of the last gravity restart and lock entry, key hold ages.
    localparam int M_SPAWN = 0, M_FALL = 1, M_LW = 2, M_LOCK = 3, M_OVER = 4;
    int       m_state, t, t_grav, t_lock;
    int       m_age [3];
    bit [3:0] m_prev;
    bit       e_a, e_d, e_s, e_r, e_ns, e_lock, e_go;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = M_SPAWN;
        t = 0; t_grav = 0; t_lock = 0;
        m_age = '{0, 0, 0};
        m_prev = '0;
        {e_a, e_d, e_s, e_r, e_ns, e_lock, e_go} = '0;
    endtask

    task automatic model_edge();
        bit [3:0] k, rise;
        bit [2:0] fire;
        bit want_l, want_r, want_ro, side, to_lock;
        k = {key_rotate, key_down, key_right, key_left};
        rise = k & ~m_prev;
        for (int i = 0; i < 3; i++) begin
            fire[i] = 1'b0;
            if (rise[i]) begin
                m_age[i] = 0;
                fire[i] = 1'b1;
            end else if (k[i]) begin
                m_age[i]++;
                fire[i] = (m_age[i] % R == 0);
            end
        end
        m_prev = k;
        t++;
        {e_a, e_d, e_s, e_r, e_ns} = '0;
        want_l  = fire[0] && !leftEdge && !(key_left && key_right);
        want_r  = fire[1] && !rightEdge && !(key_left && key_right);
        want_ro = rise[3];
        side    = want_l || want_r || want_ro;
        to_lock = (m_state == M_LW) && bottomEdge && ((t - t_lock >= LD) || rise[2]);
        if ((m_state == M_FALL || m_state == M_LW) && !to_lock) begin
            if (want_l) e_a = 1'b1;
            else if (want_r) e_d = 1'b1;
            else if (want_ro) e_r = 1'b1;
        end
        case (m_state)
            M_SPAWN: begin
                m_age = '{0, 0, 0};
                if (spawn_blocked) m_state = M_OVER;
                else begin
                    e_ns = 1'b1;
                    m_state = M_FALL;
                    t_grav = t;
                end
            end
            M_FALL: begin
                if (bottomEdge) begin
                    m_state = M_LW;
                    t_lock = t;
                end else if (!side && (fire[2] || (t - t_grav >= G))) begin
                    e_s = 1'b1;
                    t_grav = t;
                end
            end
            M_LW: begin
                if (!bottomEdge) begin
                    m_state = M_FALL;
                    t_grav = t;
                end else if (to_lock) m_state = M_LOCK;
            end
            M_LOCK: if (lock_done) m_state = M_SPAWN;
            default: ;
        endcase
        e_lock = (m_state == M_LOCK);
        e_go   = (m_state == M_OVER);
    endtask

    task automatic check_all();
        chk($sformatf("f%0d.a_enable", t), a_enable, e_a);
        chk($sformatf("f%0d.d_enable", t), d_enable, e_d);
        chk($sformatf("f%0d.s_enable", t), s_enable, e_s);
        chk($sformatf("f%0d.r_enable", t), r_enable, e_r);
        chk($sformatf("f%0d.newShape", t), newShape, e_ns);
        chk($sformatf("f%0d.lock_req", t), lock_req, e_lock);
        chk($sformatf("f%0d.game_over", t), game_over, e_go);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_edge();
        @(negedge frame_clk);
        check_all();
    endtask

    task automatic check_zero(input string where);
        chk({where, ".a_enable"}, a_enable, 1'b0);
        chk({where, ".d_enable"}, d_enable, 1'b0);
        chk({where, ".s_enable"}, s_enable, 1'b0);
        chk({where, ".r_enable"}, r_enable, 1'b0);
        chk({where, ".newShape"}, newShape, 1'b0);
        chk({where, ".lock_req"}, lock_req, 1'b0);
        chk({where, ".game_over"}, game_over, 1'b0);
    endtask

    // Entered at a falling edge: assert mid-frame, confirm outputs drop at once, release on the next falling edge.
    task automatic do_reset(input string where);
        #2 Reset = 1'b1;
        #1 check_zero(where);
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    logic [15:0] v_a, v_d, v_s, v_ns, v_lk;
    logic        v_any;

    initial begin
        model_reset();
        #3 check_zero("reset");
        @(negedge frame_clk);
        Reset = 1'b0;

        // Idle fall: spawn at frame 1, gravity drops at 5, 9, 13.
        v_s = '0; v_ns = '0;
        for (int f = 1; f <= 13; f++) begin
            tick();
            v_s[f-1] = s_enable;
            v_ns[f-1] = newShape;
        end
        chk("idle_s_frames", v_s, 16'h1110);
        chk("idle_newshape_frames", v_ns, 16'h0001);

        // Held left with repeat, wall reached mid-hold.
        key_left = 1'b1; v_a = '0;
        for (int f = 0; f < 5; f++) begin
            if (f == 3) leftEdge = 1'b1;
            tick();
            v_a[f] = a_enable;
        end
        chk("hold_left_a_frames", v_a, 16'h0005);
        key_left = 1'b0; leftEdge = 1'b0;
        tick(); tick();

        // Left press on a gravity frame: gravity deferred one frame.
        key_left = 1'b1; v_a = '0; v_s = '0;
        for (int f = 0; f < 6; f++) begin
            if (f == 1) key_left = 1'b0;
            tick();
            v_a[f] = a_enable;
            v_s[f] = s_enable;
        end
        chk("collide_a_frames", v_a, 16'h0001);
        chk("collide_s_frames", v_s, 16'h0022);

        // Grounded: lock after delay, commit, respawn.
        bottomEdge = 1'b1; v_lk = '0; v_ns = '0;
        for (int f = 0; f < 8; f++) begin
            if (f == 6) lock_done = 1'b1;
            if (f == 7) begin lock_done = 1'b0; bottomEdge = 1'b0; end
            tick();
            v_lk[f] = lock_req;
            v_ns[f] = newShape;
        end
        chk("lock_req_frames", v_lk, 16'h0038);
        chk("respawn_frames", v_ns, 16'h0080);

        // Slide off a ledge during lock wait.
        v_d = '0; v_s = '0; v_lk = '0;
        for (int f = 0; f < 7; f++) begin
            if (f == 0) bottomEdge = 1'b1;
            if (f == 1) key_right = 1'b1;
            if (f == 2) begin key_right = 1'b0; bottomEdge = 1'b0; end
            tick();
            v_d[f] = d_enable;
            v_s[f] = s_enable;
            v_lk[f] = lock_req;
        end
        chk("slide_d_frames", v_d, 16'h0002);
        chk("slide_s_frames", v_s, 16'h0040);
        chk("slide_lock_req", v_lk, 16'h0000);

        // Hard lock via key_down, then asynchronous reset while in LOCK.
        bottomEdge = 1'b1; tick();
        key_down = 1'b1; tick();
        chk("hard_lock_req", lock_req, 1'b1);
        key_down = 1'b0; bottomEdge = 1'b0;
        do_reset("reset_mid_lock");
        tick();
        chk("post_reset_newshape", newShape, 1'b1);

        // Blocked spawn: game over, keys ignored, reset recovers.
        spawn_blocked = 1'b1;
        do_reset("reset_before_over");
        tick();
        chk("over_game_over", game_over, 1'b1);
        chk("over_no_newshape", newShape, 1'b0);
        spawn_blocked = 1'b0; v_any = 1'b0;
        for (int f = 0; f < 4; f++) begin
            key_left = 1'(f); key_right = 1'(f >> 1); key_rotate = 1'(~f); key_down = 1'(f);
            tick();
            v_any = v_any | a_enable | d_enable | s_enable | r_enable | newShape | lock_req;
        end
        chk("over_outputs_quiet", v_any, 1'b0);
        {key_left, key_right, key_down, key_rotate} = '0;
        do_reset("reset_from_over");
        tick();
        chk("over_exit_newshape", newShape, 1'b1);

        // Randomized play.
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset($sformatf("rand_reset_%0d", n));
            if ($urandom_range(0, 5) == 0) key_left = ~key_left;
            if ($urandom_range(0, 5) == 0) key_right = ~key_right;
            if ($urandom_range(0, 5) == 0) key_down = ~key_down;
            if ($urandom_range(0, 4) == 0) key_rotate = ~key_rotate;
            if ($urandom_range(0, 5) == 0) bottomEdge = ~bottomEdge;
            leftEdge = ($urandom_range(0, 4) == 0);
            rightEdge = ($urandom_range(0, 4) == 0);
            spawn_blocked = ($urandom_range(0, 15) == 0);
            lock_done = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
